// File: rtl/counter_bin_writer.sv
// Pulse-counting acquisition front end: counts synchronised rising edges of i_pulse over
// back-to-back gate windows and writes each bin count into a ring buffer on SRAM port A.
module counter_bin_writer #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned GATE_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_pulse,
  input  logic [GATE_WIDTH-1:0] i_gate_len,
  input  logic [ADDR_WIDTH:0]   i_num_bins,
  input  logic                  i_start,
  input  logic                  i_stop,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_we,
  output logic [DATA_WIDTH-1:0] o_sram_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_wrapped,
  output logic                  o_saturated,
  output logic [ADDR_WIDTH-1:0] o_write_ptr
);

  localparam logic [ADDR_WIDTH:0]   DepthBins = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] CountMax  = '1;
  localparam logic [GATE_WIDTH-1:0] GateOne   = GATE_WIDTH'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                  state_q, state_d;
  logic                    sync1_q, sync2_q, sync3_q;
  logic                    pulse_edge;
  logic [GATE_WIDTH-1:0]   gate_len_q, gate_len_d;
  logic [GATE_WIDTH-1:0]   cycle_q, cycle_d;
  logic [ADDR_WIDTH:0]     num_bins_q, num_bins_d;
  logic [ADDR_WIDTH:0]     bins_q, bins_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    wrapped_q, wrapped_d;
  logic                    sat_q, sat_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;

  logic                    bin_end;
  logic                    acc_full;
  logic [DATA_WIDTH-1:0]   acc_inc;
  logic [DATA_WIDTH-1:0]   bin_total;
  logic [ADDR_WIDTH-1:0]   ptr_next;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    ring_mode;
  logic                    last_bin;

  // Two-flop synchroniser followed by a history flop for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= i_pulse;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign pulse_edge = sync2_q & ~sync3_q;

  always_comb begin
    bin_end   = (cycle_q == gate_len_q - GateOne);
    acc_full  = (acc_q == CountMax);
    acc_inc   = acc_full ? acc_q : acc_q + 1'b1;
    bin_total = pulse_edge ? acc_inc : acc_q;
    ptr_next  = (ptr_q == LastAddr) ? '0 : ptr_q + 1'b1;
    // A write in flight advances the pointer this cycle, so the next bin targets ptr_next.
    wr_addr   = we_q ? ptr_next : ptr_q;
    ring_mode = (num_bins_q == '0);
    last_bin  = !ring_mode && ((bins_q + 1'b1) == num_bins_q);
  end

  always_comb begin
    state_d    = state_q;
    gate_len_d = gate_len_q;
    cycle_d    = cycle_q;
    num_bins_d = num_bins_q;
    bins_d     = bins_q;
    acc_d      = acc_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    data_d     = data_q;
    done_d     = done_q;
    wrapped_d  = wrapped_q;
    sat_d      = sat_q;
    ptr_d      = ptr_q;

    if (we_q) begin
      ptr_d = ptr_next;
      if (ring_mode && (ptr_q == LastAddr)) begin
        wrapped_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          gate_len_d = (i_gate_len == '0) ? GateOne : i_gate_len;
          num_bins_d = (i_num_bins > DepthBins) ? DepthBins : i_num_bins;
          cycle_d    = '0;
          bins_d     = '0;
          acc_d      = '0;
          ptr_d      = '0;
          done_d     = 1'b0;
          wrapped_d  = 1'b0;
          sat_d      = 1'b0;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (pulse_edge && acc_full) begin
          sat_d = 1'b1;
        end
        if (bin_end) begin
          // An edge on the closing cycle still belongs to the bin being written.
          cycle_d = '0;
          acc_d   = '0;
          we_d    = 1'b1;
          addr_d  = wr_addr;
          data_d  = bin_total;
          bins_d  = bins_q + 1'b1;
          if (last_bin) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else if (i_stop) begin
            state_d = StIdle;
          end
        end else begin
          cycle_d = cycle_q + GateOne;
          if (pulse_edge) begin
            acc_d = acc_inc;
          end
          if (i_stop) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      gate_len_q <= GateOne;
      cycle_q    <= '0;
      num_bins_q <= '0;
      bins_q     <= '0;
      acc_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
      wrapped_q  <= 1'b0;
      sat_q      <= 1'b0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      gate_len_q <= gate_len_d;
      cycle_q    <= cycle_d;
      num_bins_q <= num_bins_d;
      bins_q     <= bins_d;
      acc_q      <= acc_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      data_q     <= data_d;
      done_q     <= done_d;
      wrapped_q  <= wrapped_d;
      sat_q      <= sat_d;
      ptr_q      <= ptr_d;
    end
  end

  assign o_sram_addr = addr_q;
  assign o_sram_we   = we_q;
  assign o_sram_data = data_q;
  assign o_busy      = (state_q == StRun);
  assign o_done      = done_q;
  assign o_wrapped   = wrapped_q;
  assign o_saturated = sat_q;
  assign o_write_ptr = ptr_q;

endmodule
